// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a 2-bit bimodal branch predictor.
//
// Issues at most one outstanding instruction-memory request. At 1-cycle memory
// latency it delivers one instruction per cycle. The next request address is
// produced in the same cycle as the delivery, using the BHT (conditional
// branches) or an unconditional JAL target.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   stall_i                 IF/ID is holding, so the current delivery is not consumed
//   redirect_i/_pc_i        EX-stage correction; highest priority
//   update_valid_i/_pc_i/_taken_i   resolved conditional branch, trains the BHT
//   imem_req_o/_addr_o      single-cycle fetch request pulse and address
//   imem_valid_i/_rdata_i   memory response strobe and instruction word
//   instruction_o, pc_o, br_pred_o  delivered word, its PC, predicted-taken flag
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        br_pred_o
);

    localparam int          IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD, ST_DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_instr;
    logic        hold_pred;
    logic        capture;
    logic [1:0]  bht [BHT_ENTRIES];

    // Bits of the update PC outside the index field never matter.
    logic unused_upd_bits;
    assign unused_upd_bits = ^{update_pc_i[31:IDX_W+2], update_pc_i[1:0]};

    // Decode of the word being delivered (live response or the held copy).
    logic [31:0] word, b_imm, j_imm, target, next_pc;
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic is_br, is_jal, pred_live, pred;

    assign word      = (state == ST_HOLD) ? hold_instr : imem_rdata_i;
    assign is_br     = (word[6:0] == 7'b1100011);
    assign is_jal    = (word[6:0] == 7'b1101111);
    assign b_imm     = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
    assign j_imm     = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    assign lk_idx    = pc[IDX_W+1:2];
    assign upd_idx   = update_pc_i[IDX_W+1:2];
    // Lookup reads the register array directly, so a same-cycle update of the
    // same entry is seen only from the next cycle on.
    assign pred_live = is_jal | (is_br & bht[lk_idx][1]);
    // A held word keeps the prediction it had when it first arrived.
    assign pred      = (state == ST_HOLD) ? hold_pred : pred_live;
    assign target    = pc + (is_jal ? j_imm : b_imm);
    assign next_pc   = pred ? target : pc + 32'd4;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        capture       = 1'b0;
        imem_req_o    = 1'b0;
        imem_addr_o   = pc;
        instruction_o = NOP;
        pc_o          = pc;
        br_pred_o     = 1'b0;
        if (redirect_i) begin
            pc_nxt    = redirect_pc_i;
            // A request still in flight must be drained before refetching.
            state_nxt = (state == ST_WAIT && !imem_valid_i) ? ST_DROP : ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    imem_req_o = 1'b1;
                    state_nxt  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_valid_i) begin
                        instruction_o = word;
                        br_pred_o     = pred;
                        if (!stall_i) begin
                            imem_req_o  = 1'b1;
                            imem_addr_o = next_pc;
                            pc_nxt      = next_pc;
                        end else begin
                            capture   = 1'b1;
                            state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    instruction_o = word;
                    br_pred_o     = pred;
                    if (!stall_i) begin
                        imem_req_o  = 1'b1;
                        imem_addr_o = next_pc;
                        pc_nxt      = next_pc;
                        state_nxt   = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (imem_valid_i) state_nxt = ST_REQ;
                end
                default: state_nxt = ST_REQ;
            endcase
        end
        // State is already REQ while reset is held; keep the bus quiet.
        if (!reset_n) imem_req_o = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            hold_instr <= '0;
            hold_pred  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                hold_instr <= imem_rdata_i;
                hold_pred  <= pred_live;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (update_valid_i) begin
            if (update_taken_i && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            else if (!update_taken_i && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
        end
    end

endmodule
